// File: rtl/bypass_queue.sv
// Ring-buffer queue with an optional zero-latency pass-through when empty.
// The level, almost-full/almost-empty flags and a high-water mark are derived from the write/read counters.
module bypass_queue #(
    parameter int QUEUE_DEPTH_WIDTH  = 3,
    parameter int DATA_WIDTH         = 8,
    parameter int BYPASS             = 1,
    parameter int ALMOST_FULL_LEVEL  = (1 << QUEUE_DEPTH_WIDTH) - 1,
    parameter int ALMOST_EMPTY_LEVEL = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    input  logic                         out_ready,
    output logic [QUEUE_DEPTH_WIDTH:0]   level,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [QUEUE_DEPTH_WIDTH:0]   high_water
);
    localparam int DEPTH = 1 << QUEUE_DEPTH_WIDTH;
    localparam logic [QUEUE_DEPTH_WIDTH:0] L_DEPTH  = (QUEUE_DEPTH_WIDTH+1)'(DEPTH);
    localparam logic [QUEUE_DEPTH_WIDTH:0] L_AF_LVL = (QUEUE_DEPTH_WIDTH+1)'(ALMOST_FULL_LEVEL);
    localparam logic [QUEUE_DEPTH_WIDTH:0] L_AE_LVL = (QUEUE_DEPTH_WIDTH+1)'(ALMOST_EMPTY_LEVEL);

    logic [QUEUE_DEPTH_WIDTH:0] r_wr_ptr;
    logic [QUEUE_DEPTH_WIDTH:0] r_rd_ptr;
    logic [QUEUE_DEPTH_WIDTH:0] r_high_water;
    logic [DATA_WIDTH-1:0]      r_mem [DEPTH];

    logic                       w_empty;
    logic                       w_full;
    logic                       w_block;
    logic                       w_push;
    logic                       w_pop;
    logic [QUEUE_DEPTH_WIDTH:0] w_level;
    logic [QUEUE_DEPTH_WIDTH:0] w_wr_next;
    logic [QUEUE_DEPTH_WIDTH:0] w_rd_next;
    logic [QUEUE_DEPTH_WIDTH:0] w_level_next;
    logic [DATA_WIDTH-1:0]      w_head;

    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_empty = (w_level == '0);
    assign w_full  = (w_level == L_DEPTH);
    assign w_block = reset | flush;
    assign w_head  = r_mem[r_rd_ptr[QUEUE_DEPTH_WIDTH-1:0]];

    // Pass-through mode: a full queue still accepts when the head leaves in the same cycle.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = w_head;
        if (BYPASS != 0) begin
            in_ready  = !w_block && (!w_full || out_ready);
            out_valid = !w_block && (!w_empty || in_valid);
            out_data  = w_empty ? in_data : w_head;
        end else begin
            in_ready  = !w_block && !w_full;
            out_valid = !w_block && !w_empty;
        end
    end

    assign w_push       = in_valid & in_ready;
    assign w_pop        = out_valid & out_ready;
    assign w_wr_next    = r_wr_ptr + (QUEUE_DEPTH_WIDTH+1)'(w_push);
    assign w_rd_next    = r_rd_ptr + (QUEUE_DEPTH_WIDTH+1)'(w_pop);
    assign w_level_next = w_wr_next - w_rd_next;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_high_water <= '0;
        end else begin
            r_wr_ptr <= w_wr_next;
            r_rd_ptr <= w_rd_next;
            if (w_level_next > r_high_water)
                r_high_water <= w_level_next;
        end
    end

    // Every accepted word is stored, even when it is bypassed straight to the output.
    always_ff @(posedge clock) begin
        if (w_push)
            r_mem[r_wr_ptr[QUEUE_DEPTH_WIDTH-1:0]] <= in_data;
    end

    assign level        = w_level;
    assign high_water   = r_high_water;
    assign almost_full  = (w_level >= L_AF_LVL);
    assign almost_empty = (w_level <= L_AE_LVL);
endmodule

// File: tb/tb_bypass_queue.sv
// Drives a bypassing and a registered-only queue with shared stimulus and compares each against its own list model.
module tb_bypass_queue;
    logic        clock;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;

    logic [1:0]       ir;
    logic [1:0]       ov;
    logic [1:0][15:0] od;
    logic [1:0][2:0]  lv;
    logic [1:0][2:0]  hw;
    logic [1:0]       af;
    logic [1:0]       ae;

    int checks   = 0;
    int failures = 0;

    // Model: per instance, an ordered list of accepted words addressed by ever-growing head/tail counts.
    logic [15:0] m_buf [2][256];
    int          m_head [2];
    int          m_tail [2];
    int          m_hw   [2];
    bit          m_init = 1'b0;
    int          seq;

    bypass_queue #(
        .QUEUE_DEPTH_WIDTH(2), .DATA_WIDTH(16), .BYPASS(1),
        .ALMOST_FULL_LEVEL(3), .ALMOST_EMPTY_LEVEL(1)
    ) dut_byp (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(ir[1]),
        .out_valid(ov[1]), .out_data(od[1]), .out_ready(out_ready),
        .level(lv[1]), .almost_full(af[1]), .almost_empty(ae[1]), .high_water(hw[1])
    );

    bypass_queue #(
        .QUEUE_DEPTH_WIDTH(2), .DATA_WIDTH(16), .BYPASS(0),
        .ALMOST_FULL_LEVEL(3), .ALMOST_EMPTY_LEVEL(1)
    ) dut_reg (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(ir[0]),
        .out_valid(ov[0]), .out_data(od[0]), .out_ready(out_ready),
        .level(lv[0]), .almost_full(af[0]), .almost_empty(ae[0]), .high_water(hw[0])
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_hs(input int b, output bit e_ir, output bit e_ov);
        int cnt;
        cnt  = m_tail[b] - m_head[b];
        e_ir = !reset && !flush && ((cnt < 4) || (b == 1 && out_ready));
        e_ov = !reset && !flush && ((cnt > 0) || (b == 1 && in_valid));
    endtask

    task automatic check_all();
        for (int b = 0; b < 2; b++) begin
            bit    e_ir;
            bit    e_ov;
            int    cnt;
            string p;
            p   = (b == 1) ? "byp." : "reg.";
            cnt = m_tail[b] - m_head[b];
            expect_hs(b, e_ir, e_ov);
            check({p, "in_ready"}, 32'(ir[b]), 32'(e_ir));
            check({p, "out_valid"}, 32'(ov[b]), 32'(e_ov));
            if (e_ov)
                check({p, "out_data"}, 32'(od[b]),
                      32'((cnt > 0) ? m_buf[b][m_head[b] % 256] : in_data));
            check({p, "level"}, 32'(lv[b]), 32'(cnt));
            check({p, "almost_full"}, 32'(af[b]), 32'(cnt >= 3));
            check({p, "almost_empty"}, 32'(ae[b]), 32'(cnt <= 1));
            check({p, "high_water"}, 32'(hw[b]), 32'(m_hw[b]));
        end
    endtask

    task automatic update_model();
        for (int b = 0; b < 2; b++) begin
            bit e_ir;
            bit e_ov;
            expect_hs(b, e_ir, e_ov);
            if (reset || flush) begin
                m_head[b] = m_tail[b];
                m_hw[b]   = 0;
            end else begin
                if (in_valid && e_ir) begin
                    m_buf[b][m_tail[b] % 256] = in_data;
                    m_tail[b]++;
                end
                if (e_ov && out_ready)
                    m_head[b]++;
                if (m_tail[b] - m_head[b] > m_hw[b])
                    m_hw[b] = m_tail[b] - m_head[b];
            end
        end
    endtask

    task automatic tick();
        #1;
        if (m_init) check_all();
        @(posedge clock);
        update_model();
        @(negedge clock);
    endtask

    task automatic drive(input bit v, input logic [15:0] d, input bit r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        drive(1'b0, '0, 1'b0);
        @(posedge clock);
        @(negedge clock);
        for (int b = 0; b < 2; b++) begin
            m_head[b] = 0; m_tail[b] = 0; m_hw[b] = 0;
        end
        m_init = 1'b1;
        drive(1'b1, 16'hBEEF, 1'b1);
        tick();
        reset = 1'b0;
        drive(1'b0, '0, 1'b0);
        tick();

        // Zero-latency pass-through on the bypassing instance.
        drive(1'b1, 16'h00A5, 1'b1);
        #1;
        check("pass.out_valid", 32'(ov[1]), 32'd1);
        check("pass.out_data", 32'(od[1]), 32'h00A5);
        tick();
        check("pass.level", 32'(lv[1]), 32'd0);
        drive(1'b0, '0, 1'b1);
        tick();

        // Fill to full, then push and pop together while full.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 16'(i), 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b0);
        #1;
        check("full.level", 32'(lv[1]), 32'd4);
        check("full.in_ready", 32'(ir[1]), 32'd0);
        check("full.almost_full", 32'(af[1]), 32'd1);
        tick();
        drive(1'b1, 16'h0005, 1'b1);
        #1;
        check("fullpp.in_ready", 32'(ir[1]), 32'd1);
        check("fullpp.out_data", 32'(od[1]), 32'h0001);
        tick();
        check("fullpp.level", 32'(lv[1]), 32'd4);

        // Registered-only first-word latency.
        reset = 1'b1; drive(1'b0, '0, 1'b0); tick(); reset = 1'b0;
        drive(1'b1, 16'h1234, 1'b1);
        #1;
        check("lat.push_cycle_valid", 32'(ov[0]), 32'd0);
        tick();
        drive(1'b0, '0, 1'b1);
        #1;
        check("lat.next_valid", 32'(ov[0]), 32'd1);
        check("lat.next_data", 32'(od[0]), 32'h1234);
        tick();

        // Flush at level 3 with a push offered.
        reset = 1'b1; drive(1'b0, '0, 1'b0); tick(); reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'(16'h0100 + i), 1'b0);
            tick();
        end
        flush = 1'b1; drive(1'b1, 16'h0777, 1'b1); tick(); flush = 1'b0;
        drive(1'b0, '0, 1'b1);
        #1;
        check("flush.level", 32'(lv[0]), 32'd0);
        check("flush.high_water", 32'(hw[0]), 32'd0);
        check("flush.out_valid", 32'(ov[0]), 32'd0);
        tick();

        // Reset and flush together at level 2; old data must not reappear.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 16'(16'h0200 + i), 1'b0);
            tick();
        end
        reset = 1'b1; flush = 1'b1; drive(1'b1, 16'h0999, 1'b1); tick();
        reset = 1'b0; flush = 1'b0; drive(1'b0, '0, 1'b1);
        #1;
        check("rstfl.level", 32'(lv[1]), 32'd0);
        check("rstfl.high_water", 32'(hw[1]), 32'd0);
        check("rstfl.in_ready", 32'(ir[0]), 32'd1);
        for (int i = 0; i < 3; i++) tick();

        // Random stream of 0x0000..0x0013 into the registered instance's acceptance order.
        reset = 1'b1; drive(1'b0, '0, 1'b0); tick(); reset = 1'b0;
        seq = 0;
        for (int c = 0; c < 200; c++) begin
            bit v;
            v = (seq < 20) && ($urandom_range(0, 3) != 0);
            drive(v, 16'(seq), (c < 60) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1));
            if (v && (m_tail[0] - m_head[0] < 4)) seq++;
            tick();
        end
        check("stream.all_sent", 32'(seq), 32'd20);

        // Random traffic with occasional flush/reset, exercising counter wrap.
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 59) == 0);
            flush = ($urandom_range(0, 39) == 0);
            drive($urandom_range(0, 1) == 1, 16'($urandom), $urandom_range(0, 2) != 0);
            tick();
        end
        reset = 1'b0; flush = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
